sequential_divider_signed: RTL and testbench

- Iterative signed integer divider; the inverse operator to the team's pipelined signed multiplier.
- Takes a 32-bit two's-complement dividend and a 16-bit two's-complement divisor.
- Returns a 32-bit quotient and 16-bit remainder using truncating (round-toward-zero) semantics.
- Uses the same sign/magnitude strategy as the multiplier: strip signs, run an unsigned radix-2 restoring divide, reapply signs. Sits on the datapath behind a valid/ready handshake.

---
 rtl/sequential_divider_signed_pkg.sv | 14 +
 rtl/sequential_divider_signed_twos_mag.sv | 12 +
 rtl/sequential_divider_signed.sv | 159 +++++++++++++++
 tb/tb_sequential_divider_signed.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sequential_divider_signed_pkg.sv
// Shared types and defaults for the iterative signed divider.
package div_pkg;

   typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} div_state_e;

   localparam int DIV_DEFAULT_DW = 32;
   localparam int DIV_DEFAULT_VW = 16;

   // Cycles from the accept edge to the first out_valid for a nonzero divisor.
   function automatic int div_latency(input int dw);
      return dw + 2;
   endfunction

endpackage

// File: rtl/sequential_divider_signed_twos_mag.sv
// Conditional two's-complement negate, used both to strip and to reapply signs.
module twos_mag #(
   parameter int W = 16
) (
   input  logic         neg,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/sequential_divider_signed.sv
// Iterative signed divider: sign/magnitude around a radix-2 restoring divide.
// Define DIV_REM_EN to compute the signed remainder; otherwise remainder reads 0.
module sequential_divider_signed
   import div_pkg::*;
#(
   parameter int DW = DIV_DEFAULT_DW,
   parameter int VW = DIV_DEFAULT_VW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero,
   output logic          overflow
);

   localparam int CW = $clog2(DW);

   div_state_e    state_r;
   logic          in_ready_r;
   logic          out_valid_r;
   logic [DW-1:0] quotient_r;
   logic          div_by_zero_r;
   logic          overflow_r;

   logic [DW-1:0] dividend_r;
   logic [VW-1:0] divisor_r;
   logic          sign_q_r;
   logic [DW-1:0] acc_r;
   logic [VW-1:0] dvs_r;
   logic [VW-1:0] prem_r;
   logic [CW-1:0] cnt_r;

   logic [DW-1:0] dvd_mag_s;
   logic [VW-1:0] dvs_mag_s;
   logic [DW-1:0] q_fix_s;
   logic [VW:0]   trial_s;
   logic          take_s;
   logic [VW-1:0] diff_s;

   // acc_r holds the dividend magnitude draining out of its MSB while quotient bits fill its LSB.
   assign trial_s = {prem_r, acc_r[DW-1]};
   assign take_s  = (trial_s >= {1'b0, dvs_r});
   assign diff_s  = trial_s[VW-1:0] - dvs_r;

   twos_mag #(.W(DW)) u_mag_dvd (.neg(dividend_r[DW-1]), .x(dividend_r), .y(dvd_mag_s));
   twos_mag #(.W(VW)) u_mag_dvs (.neg(divisor_r[VW-1]),  .x(divisor_r),  .y(dvs_mag_s));
   twos_mag #(.W(DW)) u_fix_q   (.neg(sign_q_r),         .x(acc_r),      .y(q_fix_s));

`ifdef DIV_REM_EN
   logic          sign_r_r;
   logic [VW-1:0] remainder_r;
   logic [VW-1:0] r_fix_s;

   twos_mag #(.W(VW)) u_fix_r (.neg(sign_r_r), .x(prem_r), .y(r_fix_s));

   // Remainder result register with its own sign capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         remainder_r <= {VW{1'b0}};
         sign_r_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE:    if (in_valid && in_ready_r) sign_r_r <= dividend[DW-1];
            PREP:    if (divisor_r == {VW{1'b0}}) remainder_r <= {VW{1'b0}};
            FIX:     remainder_r <= r_fix_s;
            default: remainder_r <= remainder_r;
         endcase
      end
   end

   assign remainder = remainder_r;
`else
   assign remainder = {VW{1'b0}};
`endif

   // Control FSM, iteration counter and shift/subtract datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         quotient_r    <= {DW{1'b0}};
         div_by_zero_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  dividend_r    <= dividend;
                  divisor_r     <= divisor;
                  sign_q_r      <= dividend[DW-1] ^ divisor[VW-1];
                  in_ready_r    <= 1'b0;
                  div_by_zero_r <= 1'b0;
                  overflow_r    <= 1'b0;
                  state_r       <= PREP;
               end
            end
            PREP: begin
               acc_r  <= dvd_mag_s;
               dvs_r  <= dvs_mag_s;
               prem_r <= {VW{1'b0}};
               cnt_r  <= CW'(DW - 1);
               if (divisor_r == {VW{1'b0}}) begin
                  div_by_zero_r <= 1'b1;
                  quotient_r    <= {DW{1'b1}};
                  state_r       <= DONE;
               end else begin
                  state_r <= DIV;
               end
            end
            DIV: begin
               prem_r <= take_s ? diff_s : trial_s[VW-1:0];
               acc_r  <= {acc_r[DW-2:0], take_s};
               if (cnt_r == {CW{1'b0}}) begin
                  state_r <= FIX;
               end else begin
                  cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            FIX: begin
               quotient_r  <= q_fix_s;
               overflow_r  <= (dividend_r == {1'b1, {(DW-1){1'b0}}}) &&
                              (divisor_r == {VW{1'b1}});
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               // Divide-by-zero arrives here straight from PREP; valid rises one edge later.
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign quotient    = quotient_r;
   assign div_by_zero = div_by_zero_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_sequential_divider_signed.sv
// Directed self-checking bench for sequential_divider_signed (remainder checks follow DIV_REM_EN).
module tb_sequential_divider_signed;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   sequential_divider_signed dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rem_exp(input logic [15:0] r);
`ifdef DIV_REM_EN
      return r;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] a, input logic [15:0] b);
      check_eq("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
      check_eq({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov, input int elat);
      int lat;
      start(a, b);
      wait_valid(lat);
      check_eq({tag, "_latency"}, 64'(lat), 64'(elat));
      check_eq({tag, "_quot"}, {32'd0, quotient}, {32'd0, eq});
      check_eq({tag, "_rem"}, {48'd0, remainder}, {48'd0, rem_exp(er)});
      check_eq({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edz});
      check_eq({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eov});
      release_out(tag);
   endtask

   initial begin
      int lat;
      int spurious;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = 32'd0; divisor = 16'd0;
      tick(); tick();
      rst = 1'b0;

      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_in_ready",  {63'd0, in_ready}, 64'd1);
      check_eq("rst_quot",      {32'd0, quotient}, 64'd0);
      check_eq("rst_rem",       {48'd0, remainder}, 64'd0);
      check_eq("rst_flags",     {62'd0, div_by_zero, overflow}, 64'd0);

      run_op("pos_pos", 32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 1'b0, 34);
      run_op("neg_pos", 32'hFFFF_FF9C,  16'd7,      32'hFFFF_FFF2,  16'hFFFE,   1'b0, 1'b0, 34);
      run_op("pos_neg", 32'd100,        16'hFFF9,   32'hFFFF_FFF2,  16'd2,      1'b0, 1'b0, 34);
      run_op("neg_neg", 32'hFFFF_FF9C,  16'hFFF9,   32'd14,         16'hFFFE,   1'b0, 1'b0, 34);
      run_op("min_m1",  32'h8000_0000,  16'hFFFF,   32'h8000_0000,  16'h0000,   1'b0, 1'b1, 34);
      run_op("min_2",   32'h8000_0000,  16'h0002,   32'hC000_0000,  16'h0000,   1'b0, 1'b0, 34);
      run_op("max_vmin",32'h7FFF_FFFF,  16'h8000,   32'hFFFF_0001,  16'h7FFF,   1'b0, 1'b0, 34);
      run_op("by_zero", 32'd12345,      16'h0000,   32'hFFFF_FFFF,  16'h0000,   1'b1, 1'b0, 2);

      // Backpressure with a competing request held on the input.
      start(32'd1000, 16'd3);
      wait_valid(lat);
      check_eq("bp_latency", 64'(lat), 64'd34);
      dividend = 32'd77; divisor = 16'd5; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         check_eq("bp_hold_ready", {63'd0, in_ready}, 64'd0);
         check_eq("bp_hold_quot",  {32'd0, quotient}, 64'd333);
         check_eq("bp_hold_rem",   {48'd0, remainder}, {48'd0, rem_exp(16'd1)});
      end
      in_valid = 1'b0;
      release_out("bp");

      // Reset during the DIV iterations.
      start(32'd1000, 16'd3);
      for (int i = 0; i < 11; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
      check_eq("midrst_ready", {63'd0, in_ready}, 64'd1);
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) spurious++;
      end
      check_eq("midrst_no_result", 64'(spurious), 64'd0);
      run_op("after_rst", 32'd50, 16'd5, 32'd10, 16'd0, 1'b0, 1'b0, 34);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
